bure_ifetch_buf: RTL and testbench
==================================

// Module: bure_ifetch_buf
// PURPOSE
//  Parametrised successor to the single-instruction fetch stage. Pipelined instruction fetch with a
//  DEPTH-entry prefetch queue and up to MAX_OUTSTANDING in-flight imem requests.
//  Handles redirects (branch/exception) by flushing the queue and discarding stale responses.
//  Sits between the instruction memory port and the decode stage (valid/ready toward decode).
// PARAMETERS
//  ADDR_WIDTH       32      fetch address width (byte address)
//  INSTR_WIDTH      32      instruction width; PC step = INSTR_WIDTH/8
//  DEPTH            4       prefetch queue entries; power of 2, >=2
//  MAX_OUTSTANDING  2       max granted-but-unanswered imem requests; 1..DEPTH
//  RESET_PC         'h0     first fetch address after reset
// PORTS
//  i_clk           in   1            clock
//  i_rstn          in   1            async active-low reset
//  i_redirect      in   1            redirect fetch; single-cycle pulse
//  i_redirect_pc   in   ADDR_WIDTH   new fetch address; low log2(INSTR_WIDTH/8) bits ignored (forced 0)
//  o_imem_req      out  1            fetch request
//  o_imem_addr     out  ADDR_WIDTH   fetch address (current PC)
//  i_imem_gnt      in   1            request accepted this cycle
//  i_imem_rvalid   in   1            response valid; responses in request order
//  i_imem_rdata    in   INSTR_WIDTH  response instruction
//  o_instr_valid   out  1            queue head valid
//  o_instr         out  INSTR_WIDTH  queue head instruction
//  o_instr_pc      out  ADDR_WIDTH   address of o_instr
//  i_instr_ready   in   1            decode accepts head (pop when valid & ready)
// BEHAVIOUR
//  - Reset: o_imem_req=0, o_imem_addr=RESET_PC, o_instr_valid=0, queue empty, outstanding=0, discard=0.
//  - o_imem_req = !i_redirect && (outstanding < MAX_OUTSTANDING) && (count + outstanding < DEPTH).
//    Credit rule guarantees every response has a queue slot; queue never overflows.
//  - req & gnt: PC += INSTR_WIDTH/8 (wraps modulo 2^ADDR_WIDTH), outstanding++.
//  - rvalid: outstanding--; if discard>0 then discard-- and data dropped, else push {rdata, pc_of_req}.
//    pc_of_req is held in a MAX_OUTSTANDING-deep address FIFO of granted addresses.
//  - Simultaneous gnt and rvalid: outstanding unchanged; push and PC advance both occur.
//  - Pop on o_instr_valid & i_instr_ready; simultaneous push/pop at full or empty is legal.
//  - Redirect (highest priority): queue cleared, pop ignored, PC<=i_redirect_pc, o_imem_req=0 that cycle;
//    discard <= outstanding - (rvalid?1:0) (the gnt term is 0 since req is low). Any rvalid that cycle is dropped.
//    First new request next cycle. o_instr_valid=0 from next cycle until a non-stale response lands.
//  - Redirect while discard>0: discard accumulates the same way; no stale data ever reaches decode.
//  - Latency (macro off): rvalid in cycle N -> o_instr_valid in N+1.
//  - Reset mid-operation: all state to reset values asynchronously; late responses after reset are
//    the memory's responsibility (imem is reset with the core).
//  - rvalid with outstanding==0 is illegal; assertion fires; state unchanged.
// CONFIGURATION
//  BURE_IFETCH_BYPASS_EN defined: when the queue is empty, discard==0 and !i_redirect, a response
//    drives o_instr/o_instr_valid/o_instr_pc combinationally in the same cycle. If consumed
//    (i_instr_ready), it is not pushed. Otherwise it is pushed as normal. Latency is 0 cycles.
//  Not defined: all responses go through the queue (1-cycle latency); there is no rvalid->o_instr_valid path.
// STRUCTURE
//  - bure_pkg: INSTR_BYTES localparam, default ADDR/INSTR widths, fetch_entry_t {instr, pc} for 32/32.
//  - Sub-module bure_sync_fifo #(WIDTH,DEPTH): synchronous FIFO with flush, count, full/empty.
//    Instantiated twice: the prefetch queue, and the in-flight address FIFO (DEPTH=MAX_OUTSTANDING).
// TESTING
//  1. Reset release, gnt=1, 1-cycle rvalid, ready=1 -> addrs 0,4,8,..; instr/pc stream in order, no bubbles.
//  2. ready=0, gnt=1 -> exactly DEPTH=4 entries accepted; req drops when count+outstanding==4; nothing lost.
//  3. Two outstanding (addr 0x10, 0x14), redirect to 0x103 -> next req addr 0x100; both old responses
//     dropped; first o_instr_pc=0x100.
//  4. Redirect in the same cycle as rvalid with outstanding=2 -> that rvalid is dropped, discard=1,
//     the next stale response is also dropped.
//  5. PC=0xFFFF_FFFC, gnt -> next addr 0x0000_0000 (wrap).
//  6. BYPASS_EN, queue empty, rvalid & ready -> o_instr_valid same cycle, queue count stays 0; off -> +1 cycle.

Source files
------------

// File: rtl/bure_pkg.sv
// Shared fetch-path widths, decode-facing entry type and small helpers.
package bure_pkg;

    localparam int BURE_ADDR_W  = 32;
    localparam int BURE_INSTR_W = 32;
    localparam int INSTR_BYTES  = BURE_INSTR_W / 8;

    typedef struct packed {
        logic [BURE_INSTR_W-1:0] instr;
        logic [BURE_ADDR_W-1:0]  pc;
    } fetch_entry_t;

    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bure_sync_fifo.sv
// Synchronous FIFO with flush, occupancy count and full/empty flags.
module bure_sync_fifo
    import bure_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= nxt(wptr);
            if (pop)  rptr <= nxt(rptr);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wptr] <= wdata;
    end

    assign rdata = mem[rptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/bure_ifetch_buf.sv
// Pipelined fetch with prefetch queue and redirect flush.
// Optional macro BURE_IFETCH_BYPASS_EN: zero-latency response path to decode.
module bure_ifetch_buf
    import bure_pkg::*;
#(
    parameter int ADDR_WIDTH      = BURE_ADDR_W,
    parameter int INSTR_WIDTH     = BURE_INSTR_W,
    parameter int DEPTH           = 4,
    parameter int MAX_OUTSTANDING = 2,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                   i_clk,
    input  logic                   i_rstn,
    input  logic                   i_redirect,
    input  logic [ADDR_WIDTH-1:0]  i_redirect_pc,
    output logic                   o_imem_req,
    output logic [ADDR_WIDTH-1:0]  o_imem_addr,
    input  logic                   i_imem_gnt,
    input  logic                   i_imem_rvalid,
    input  logic [INSTR_WIDTH-1:0] i_imem_rdata,
    output logic                   o_instr_valid,
    output logic [INSTR_WIDTH-1:0] o_instr,
    output logic [ADDR_WIDTH-1:0]  o_instr_pc,
    input  logic                   i_instr_ready
);

    localparam int STEP = INSTR_WIDTH / 8;
    localparam int CW   = $clog2(DEPTH + 1);
    localparam int OW   = $clog2(MAX_OUTSTANDING + 1);
    localparam int EW   = INSTR_WIDTH + ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ALIGN = ~ADDR_WIDTH'(STEP - 1);

    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] req_pc;
    logic [OW-1:0]         discard;
    logic [OW-1:0]         inflight;
    logic [CW-1:0]         q_count;
    logic [CW:0]           occ;
    logic [EW-1:0]         q_head;
    logic q_full, q_empty, af_full, af_empty;
    logic rv, fire, fresh, q_push, q_pop;

    // Credit: queued + in flight never exceeds DEPTH, so every response fits.
    assign occ        = {1'b0, q_count} + (CW+1)'(inflight);
    assign o_imem_req = i_rstn && !i_redirect && !af_full
                        && (occ < (CW+1)'(DEPTH));
    assign o_imem_addr = pc;
    assign fire  = o_imem_req && i_imem_gnt;
    assign rv    = i_imem_rvalid && !af_empty;
    assign fresh = rv && (discard == '0) && !i_redirect;
    assign q_pop = !q_empty && i_instr_ready && !i_redirect;

`ifdef BURE_IFETCH_BYPASS_EN
    logic take_byp;
    assign take_byp      = fresh && q_empty;
    assign q_push        = fresh && !(take_byp && i_instr_ready);
    assign o_instr_valid = !q_empty || take_byp;
    assign {o_instr, o_instr_pc} = take_byp ? {i_imem_rdata, req_pc} : q_head;
`else
    assign q_push        = fresh;
    assign o_instr_valid = !q_empty;
    assign {o_instr, o_instr_pc} = q_head;
`endif

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            pc      <= RESET_PC;
            discard <= '0;
        end else if (i_redirect) begin
            pc      <= i_redirect_pc & ALIGN;
            discard <= inflight - OW'(rv);
        end else begin
            if (fire) pc <= pc + ADDR_WIDTH'(STEP);
            if (rv && discard != '0) discard <= discard - 1'b1;
        end
    end

    bure_sync_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_queue (
        .clk   (i_clk),
        .rst_n (i_rstn),
        .flush (i_redirect),
        .push  (q_push),
        .wdata ({i_imem_rdata, req_pc}),
        .pop   (q_pop),
        .rdata (q_head),
        .count (q_count),
        .full  (q_full),
        .empty (q_empty)
    );

    // Stale responses still retire their address, so this FIFO never flushes.
    bure_sync_fifo #(.WIDTH(ADDR_WIDTH), .DEPTH(MAX_OUTSTANDING)) u_inflight (
        .clk   (i_clk),
        .rst_n (i_rstn),
        .flush (1'b0),
        .push  (fire),
        .wdata (pc),
        .pop   (rv),
        .rdata (req_pc),
        .count (inflight),
        .full  (af_full),
        .empty (af_empty)
    );

    a_rv_legal: assert property (@(posedge i_clk) disable iff (!i_rstn)
        i_imem_rvalid |-> !af_empty);

    a_no_ovf: assert property (@(posedge i_clk) disable iff (!i_rstn)
        q_push |-> (!q_full || q_pop));

endmodule

// File: tb/tb_bure_ifetch_buf.sv
// Randomized bench for bure_ifetch_buf against a queue-based fetch model.
module tb_bure_ifetch_buf;
    import bure_pkg::*;

    localparam int DEPTH = 4;
    localparam int MAXO  = 2;

    logic        i_clk = 1'b0;
    logic        i_rstn = 1'b0;
    logic        i_redirect = 1'b0;
    logic [31:0] i_redirect_pc = '0;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_gnt = 1'b0;
    logic        i_imem_rvalid = 1'b0;
    logic [31:0] i_imem_rdata = '0;
    logic        o_instr_valid;
    logic [31:0] o_instr;
    logic [31:0] o_instr_pc;
    logic        i_instr_ready = 1'b0;

    always #5 i_clk = ~i_clk;

    bure_ifetch_buf #(
        .ADDR_WIDTH      (32),
        .INSTR_WIDTH     (32),
        .DEPTH           (DEPTH),
        .MAX_OUTSTANDING (MAXO),
        .RESET_PC        (32'h0)
    ) dut (
        .i_clk         (i_clk),
        .i_rstn        (i_rstn),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .o_imem_req    (o_imem_req),
        .o_imem_addr   (o_imem_addr),
        .i_imem_gnt    (i_imem_gnt),
        .i_imem_rvalid (i_imem_rvalid),
        .i_imem_rdata  (i_imem_rdata),
        .o_instr_valid (o_instr_valid),
        .o_instr       (o_instr),
        .o_instr_pc    (o_instr_pc),
        .i_instr_ready (i_instr_ready)
    );

    typedef struct {
        logic [31:0] addr;
        bit          stale;
    } fl_t;

    fetch_entry_t q_m[$];
    fl_t          fl_m[$];
    logic [31:0]  pc_m;
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q_m.delete();
        fl_m.delete();
        pc_m = 32'h0;
    endtask

    task automatic step();
        bit exp_req, exp_v, byp;
        fetch_entry_t head;
        fl_t f;
        #1;
        exp_req = !i_redirect && fl_m.size() < MAXO
                  && (q_m.size() + fl_m.size()) < DEPTH;
        exp_v = q_m.size() > 0;
        byp = 1'b0;
        head = '0;
        if (exp_v) head = q_m[0];
`ifdef BURE_IFETCH_BYPASS_EN
        if (!exp_v && i_imem_rvalid && !i_redirect && !fl_m[0].stale) begin
            byp = 1'b1;
            exp_v = 1'b1;
            head.instr = i_imem_rdata;
            head.pc = fl_m[0].addr;
        end
`endif
        check("imem_req", 64'(o_imem_req), 64'(exp_req));
        check("imem_addr", 64'(o_imem_addr), 64'(pc_m));
        check("instr_valid", 64'(o_instr_valid), 64'(exp_v));
        if (exp_v) begin
            check("instr", 64'(o_instr), 64'(head.instr));
            check("instr_pc", 64'(o_instr_pc), 64'(head.pc));
        end
        if (i_redirect) begin
            q_m.delete();
            if (i_imem_rvalid) fl_m.delete(0);
            foreach (fl_m[k]) fl_m[k].stale = 1'b1;
            pc_m = i_redirect_pc & ~32'h3;
        end else begin
            if (q_m.size() > 0 && i_instr_ready) q_m.delete(0);
            if (i_imem_rvalid) begin
                f = fl_m[0];
                fl_m.delete(0);
                if (!f.stale && !(byp && i_instr_ready)) begin
                    head.instr = i_imem_rdata;
                    head.pc = f.addr;
                    q_m.push_back(head);
                end
            end
            if (exp_req && i_imem_gnt) begin
                f.addr = pc_m;
                f.stale = 1'b0;
                fl_m.push_back(f);
                pc_m = pc_m + 32'd4;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        i_rstn = 1'b0;
        i_redirect = 1'b0;
        i_imem_gnt = 1'b0;
        i_imem_rvalid = 1'b0;
        i_instr_ready = 1'b0;
        #1;
        check("rst_req", 64'(o_imem_req), 64'h0);
        check("rst_addr", 64'(o_imem_addr), 64'h0);
        check("rst_valid", 64'(o_instr_valid), 64'h0);
        model_reset();
        @(negedge i_clk);
        i_rstn = 1'b1;
    endtask

    int gnt_p[6] = '{100, 100, 100, 70, 100, 50};
    int rv_p [6] = '{100, 100,  50, 70,  30, 90};
    int rdy_p[6] = '{100,   0,  50, 80, 100, 30};
    int rd_p [6] = '{  0,   0,   5, 15,  10,  8};

    initial begin
        model_reset();
        repeat (2) @(negedge i_clk);
        do_reset();
        for (int p = 0; p < 6; p++) begin
            if (p == 4) do_reset();
            for (int c = 0; c < 400; c++) begin
                if (c != 0 || p != 0) @(negedge i_clk);
                i_imem_gnt    = ($urandom_range(99) < gnt_p[p]);
                i_imem_rvalid = (fl_m.size() > 0)
                                && ($urandom_range(99) < rv_p[p]);
                i_imem_rdata  = $urandom;
                i_instr_ready = ($urandom_range(99) < rdy_p[p]);
                i_redirect    = ($urandom_range(99) < rd_p[p]);
                case ($urandom_range(3))
                    0: i_redirect_pc = $urandom;
                    1: i_redirect_pc = 32'h103;
                    2: i_redirect_pc = 32'hFFFF_FFFC;
                    default: i_redirect_pc = 32'h10;
                endcase
                step();
            end
        end
        for (int c = 0; c < 12; c++) begin
            @(negedge i_clk);
            i_imem_gnt = 1'b0;
            i_imem_rvalid = fl_m.size() > 0;
            i_imem_rdata = $urandom;
            i_instr_ready = 1'b1;
            i_redirect = 1'b0;
            step();
        end
        @(negedge i_clk);
        i_imem_rvalid = 1'b0;
        i_redirect = 1'b1;
        i_redirect_pc = 32'hFFFF_FFFE;
        step();
        @(negedge i_clk);
        i_redirect = 1'b0;
        i_imem_gnt = 1'b1;
        step();
        check("pre_wrap_addr", 64'(o_imem_addr), 64'hFFFF_FFFC);
        @(negedge i_clk);
        i_imem_gnt = 1'b0;
        step();
        check("wrap_addr", 64'(o_imem_addr), 64'h0);
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
